// File: rtl/controlador_codificador.sv
// controlador_codificador: sweeps a 4-bit encoder through all 16 input codes,
// holds Ready for a programmable settle time per code, captures the encoder
// output into a 16x4 buffer and exposes that buffer via a registered read port.
module controlador_codificador #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  output logic [3:0] Enc_Input,
  output logic       Enc_Ready,
  output logic       Enc_Reset,
  input  logic [3:0] Enc_Output,
  input  logic [3:0] Rd_Addr,
  output logic [3:0] Rd_Data,
  output logic       Busy,
  output logic       Done
);

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRIVE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_buf [16];
  logic [3:0] r_enc_input;
  logic       r_enc_ready;
  logic       r_enc_reset;
  logic [3:0] r_rd_data;
  logic       r_busy;
  logic       r_done;

  assign Enc_Input = r_enc_input;
  assign Enc_Ready = r_enc_ready;
  assign Enc_Reset = r_enc_reset;
  assign Rd_Data   = r_rd_data;
  assign Busy      = r_busy;
  assign Done      = r_done;

  // Sweep sequencer; outputs are set on the edge that enters each state so
  // they line up with the state they belong to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_buf       <= '{default: '0};
      r_enc_input <= '0;
      r_enc_ready <= 1'b0;
      r_enc_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_state     <= S_CLEAR;
            r_busy      <= 1'b1;
            r_enc_reset <= 1'b1;
            r_enc_input <= '0;
            r_idx       <= '0;
          end
        end
        S_CLEAR: begin
          r_enc_reset <= 1'b0;
          r_enc_input <= r_idx;
          r_enc_ready <= 1'b1;
          r_state     <= S_DRIVE;
        end
        S_DRIVE: begin
          r_cnt   <= LP_SETTLE;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_buf[r_idx] <= Enc_Output;
            r_enc_ready  <= 1'b0;
            r_state      <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (r_idx == 4'd15) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // DRIVE must already present the next code, so the increment is
            // forwarded straight to the encoder input here.
            r_idx       <= r_idx + 4'd1;
            r_enc_input <= r_idx + 4'd1;
            r_enc_ready <= 1'b1;
            r_state     <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered buffer read; a same-cycle write is seen only on the next read.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_buf[Rd_Addr];
    end
  end

endmodule

// File: doc/controlador_codificador.md
# controlador_codificador

Sequencer that sweeps the 4-bit `Codificador` through all 16 input codes, one at a time. For each code it drives `Input`, asserts `Ready`, waits a programmable settle time and stores the encoder's `Output` in a 16×4 result buffer. After the sweep, the buffer can be read back through a registered read port, e.g. to feed `Display` one code at a time. It sits between the top-level control (start button or bench) and the encoder datapath. It owns the encoder's `Ready` and `Reset` control pins.

## Interface
- `SETTLE`, default 2: cycles `Ready` is held after `Input` changes, before `Output` is sampled. Legal range 1..15.

- `Clock`  in  1  single system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin a sweep; sampled only in IDLE.
- `Enc_Input`  out  4  drives `Codificador.Input`.
- `Enc_Ready`  out  1  drives `Codificador.Ready`.
- `Enc_Reset`  out  1  drives `Codificador.Reset`.
- `Enc_Output`  in  4  from `Codificador.Output`.
- `Rd_Addr`  in  4  result buffer read index.
- `Rd_Data`  out  4  buffer word at `Rd_Addr`, registered.
- `Busy`  out  1  high whenever the FSM is not in IDLE.
- `Done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- Reset values:
  - outputs: `Enc_Input`=0, `Enc_Ready`=0, `Enc_Reset`=0, `Rd_Data`=0, `Busy`=0, `Done`=0.
  - internal: all 16 buffer words = 0, index = 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE → CLEAR when `Start`=1.
  - CLEAR (1 cycle): `Enc_Reset`=1, `Enc_Input`=0, index cleared to 0 → DRIVE.
  - DRIVE (1 cycle): `Enc_Input`=index, `Enc_Ready`=1, settle counter loaded with `SETTLE` → WAIT.
  - WAIT (`SETTLE` cycles): `Enc_Ready`=1, `Enc_Input` held, counter decrements. On the edge leaving the last WAIT cycle, buffer[index] ← `Enc_Output` → CAPTURE.
  - CAPTURE (1 cycle): `Enc_Ready`=0. If index=15 → DONE; else index+1 → DRIVE.
  - DONE (1 cycle): `Done`=1 → IDLE.
- `Enc_Ready` is low in IDLE, CLEAR, CAPTURE and DONE.
- `Enc_Input` holds its last value outside DRIVE/WAIT. It is forced to 0 in CLEAR.
- `Start` is ignored in every state except IDLE. It is level-sampled, so holding it high starts a new sweep on the first cycle back in IDLE.
- The index is 4 bits. The 15 → 0 wrap never occurs inside a sweep, because CAPTURE at index 15 exits to DONE.
- Read port:
  - `Rd_Data` ← buffer[`Rd_Addr`] every cycle, in any state.
  - A read of the entry being written in the same cycle returns the old value.
- `Reset` mid-sweep: takes effect at the next edge. FSM goes to IDLE, the buffer is cleared, and `Done` is not pulsed. `Reset` has priority over `Start`.

## Timing
- Let E0 be the edge at which `Start` is sampled high in IDLE. With S = `SETTLE`:
  - CLEAR occupies the cycle after E0.
  - DRIVE for code k begins at E(1 + k·(S+2)).
  - Code k is written at E(1 + k·(S+2) + 1 + S).
  - DONE begins at E(1 + 16·(S+2)); `Busy` falls one edge later.
- Worked example, S=2: DONE at E65, `Busy` low after E66. Total sweep is 66 cycles from `Start` to IDLE.
- `Busy` rises at E0 (registered from state).
- `Rd_Data` latency is 1 cycle from `Rd_Addr`.

## Test plan
- Reset check: assert `Reset` for 2 cycles → all outputs 0; any `Rd_Addr` returns 0.
- Full sweep, S=2, encoder stub `Enc_Output = Enc_Input ^ 4'b1010` → `Done` pulses exactly at E65. Then reads give buffer[5]=4'b1111, buffer[0]=4'b1010, buffer[15]=4'b0101.
- Handshake trace, S=2 → `Enc_Reset` high only in the cycle after E0. `Enc_Ready` is high for exactly 3 consecutive cycles per code, with 1 low cycle between codes. `Enc_Input` steps 0..15 in order.
- Pulse `Start` again at E10 during the sweep → ignored; `Done` still at E65 and only once. Hold `Start` high through DONE → a new sweep starts on the first IDLE cycle.
- Assert `Reset` at E30 → next cycle `Busy`=0, buffer reads return 0, no `Done` pulse. A subsequent `Start` runs a clean full sweep.
- `SETTLE`=1 and `SETTLE`=15 → `Done` at E49 and E273 respectively. Buffer contents match the stub.
